// File: rtl/huffman_encode_ctrl_pkg.sv
// huffman_pkg: shared FSM state enum, default alphabet/field sizes and slot field offset helper
package huffman_pkg;
  localparam int DEF_TOTAL_SYMBOLS = 10;
  localparam int DEF_ADDR_WIDTH = 4;
  localparam int DEF_MAXHIGHT = 10;
  localparam int DEF_BUILD_TIMEOUT = 1023;
  typedef enum logic [2:0] {IDLE, LOAD, SETTLE, BUILD, CAPTURE, READY, SHIFT} state_t;
  function automatic int slot_lsb(input int slot, input int width);
    return slot * width;
  endfunction
endpackage

// File: rtl/huffman_encode_ctrl_if.sv
// huffman_encode_ctrl_if: start/treemaker/symbol-stream/bit-stream bundle; slave = controller, master = its environment
interface huffman_encode_ctrl_if import huffman_pkg::*; #(
  parameter int TOTAL_SYMBOLS = DEF_TOTAL_SYMBOLS,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int MAXHIGHT = DEF_MAXHIGHT
);
  logic start;
  logic tm_sload;
  logic tm_en;
  logic tm_done;
  logic [TOTAL_SYMBOLS*MAXHIGHT-1:0] tm_code;
  logic [TOTAL_SYMBOLS*MAXHIGHT-1:0] tm_len;
  logic [TOTAL_SYMBOLS*ADDR_WIDTH-1:0] tm_sym;
  logic sym_valid;
  logic [ADDR_WIDTH-1:0] sym_in;
  logic sym_ready;
  logic bit_out;
  logic bit_valid;
  logic table_ready;
  logic busy;
  logic err_unknown;
  logic err_timeout;
  modport slave (
    input start, tm_done, tm_code, tm_len, tm_sym, sym_valid, sym_in,
    output tm_sload, tm_en, sym_ready, bit_out, bit_valid, table_ready, busy, err_unknown, err_timeout
  );
  modport master (
    output start, tm_done, tm_code, tm_len, tm_sym, sym_valid, sym_in,
    input tm_sload, tm_en, sym_ready, bit_out, bit_valid, table_ready, busy, err_unknown, err_timeout
  );
endinterface

// File: rtl/huffman_encode_ctrl_lookup.sv
// huffman_code_lookup: lowest-index slot whose symbol matches sym and whose length is 1..MH; ports sym/syms/lens/codes in, hit/code/len out
module huffman_code_lookup import huffman_pkg::*; #(
  parameter int N = DEF_TOTAL_SYMBOLS,
  parameter int AW = DEF_ADDR_WIDTH,
  parameter int MH = DEF_MAXHIGHT
)(
  input  logic [AW-1:0]   sym,
  input  logic [N*AW-1:0] syms,
  input  logic [N*MH-1:0] lens,
  input  logic [N*MH-1:0] codes,
  output logic            hit,
  output logic [MH-1:0]   code,
  output logic [MH-1:0]   len
);
  always_comb begin
    hit = 1'b0;
    code = '0;
    len = '0;
    for (int i = N - 1; i >= 0; i--)
      if (syms[slot_lsb(i, AW) +: AW] == sym && lens[slot_lsb(i, MH) +: MH] != '0 && lens[slot_lsb(i, MH) +: MH] <= MH'(MH)) begin
        hit = 1'b1;
        code = codes[slot_lsb(i, MH) +: MH];
        len = lens[slot_lsb(i, MH) +: MH];
      end
  end
endmodule

// File: rtl/huffman_encode_ctrl.sv
// huffman_encode_ctrl: sequences treemaker build, captures code tables, serialises symbols MSB-first; ports clk, rst_n, bus (slave)
module huffman_encode_ctrl import huffman_pkg::*; #(
  parameter int TOTAL_SYMBOLS = DEF_TOTAL_SYMBOLS,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int MAXHIGHT = DEF_MAXHIGHT,
  parameter int BUILD_TIMEOUT = DEF_BUILD_TIMEOUT
)(
  input logic clk,
  input logic rst_n,
  huffman_encode_ctrl_if.slave bus
);
  localparam int CW = $clog2(BUILD_TIMEOUT + 1);
  state_t state, nxt;
  logic [CW-1:0] bcnt;
  logic [MAXHIGHT-1:0] cnt, sreg, lk_code, lk_len;
  logic [TOTAL_SYMBOLS*ADDR_WIDTH-1:0] tab_sym;
  logic [TOTAL_SYMBOLS*MAXHIGHT-1:0] tab_len, tab_code;
  logic lk_hit, timeout, err_miss;
  huffman_code_lookup #(.N(TOTAL_SYMBOLS), .AW(ADDR_WIDTH), .MH(MAXHIGHT)) u_lookup (
    .sym(bus.sym_in), .syms(tab_sym), .lens(tab_len), .codes(tab_code),
    .hit(lk_hit), .code(lk_code), .len(lk_len)
  );
  assign timeout = state == BUILD && !bus.tm_done && bcnt == CW'(BUILD_TIMEOUT - 1);
  assign err_miss = state == READY && !bus.start && bus.sym_valid && !lk_hit;
  assign bus.bit_out = sreg[MAXHIGHT-1];
  always_comb begin
    nxt = state;
    case (state)
      IDLE:    nxt = bus.start ? LOAD : IDLE;
      LOAD:    nxt = SETTLE;
      SETTLE:  nxt = BUILD;
      BUILD:   nxt = bus.tm_done ? CAPTURE : timeout ? IDLE : BUILD;
      CAPTURE: nxt = READY;
      READY:   nxt = bus.start ? LOAD : (bus.sym_valid && lk_hit) ? SHIFT : READY;
      SHIFT:   nxt = cnt == '0 ? READY : SHIFT;
      default: nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      bcnt <= '0;
      cnt <= '0;
      sreg <= '0;
      tab_sym <= '0;
      tab_len <= '0;
      tab_code <= '0;
      bus.tm_sload <= 1'b0;
      bus.tm_en <= 1'b0;
      bus.busy <= 1'b0;
      bus.sym_ready <= 1'b0;
      bus.bit_valid <= 1'b0;
      bus.table_ready <= 1'b0;
      bus.err_unknown <= 1'b0;
      bus.err_timeout <= 1'b0;
    end else begin
      state <= nxt;
      bcnt <= state == BUILD ? bcnt + 1'b1 : '0;
      bus.tm_sload <= nxt == LOAD;
      bus.tm_en <= nxt == BUILD;
      bus.busy <= nxt inside {LOAD, SETTLE, BUILD, CAPTURE};
      bus.sym_ready <= nxt == READY;
      bus.bit_valid <= nxt == SHIFT;
      bus.table_ready <= nxt inside {READY, SHIFT};
      bus.err_unknown <= err_miss;
      bus.err_timeout <= nxt != LOAD && (bus.err_timeout || timeout);
      if (state == CAPTURE) begin
        tab_sym <= bus.tm_sym;
        tab_len <= bus.tm_len;
        tab_code <= bus.tm_code;
      end
      // code is left-aligned so the register MSB is always the next bit; it empties to zero on the last shift
      if (state == READY && nxt == SHIFT) begin
        sreg <= lk_code << (MAXHIGHT'(MAXHIGHT) - lk_len);
        cnt <= lk_len - 1'b1;
      end else if (state == SHIFT) begin
        sreg <= sreg << 1;
        cnt <= cnt - 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_huffman_encode_ctrl.sv
// tb_huffman_encode_ctrl: table-driven encode vectors plus directed build, timeout, start-priority and reset sequences
module tb_huffman_encode_ctrl;
  import huffman_pkg::*;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  int total = 0;
  int bad = 0;
  typedef struct {
    logic [3:0] sym;
    int len;
    logic [15:0] bits;
  } vec_t;
  vec_t vt[9];
  huffman_encode_ctrl_if b();
  huffman_encode_ctrl_if b2();
  huffman_encode_ctrl dut (.clk(clk), .rst_n(rst_n), .bus(b.slave));
  huffman_encode_ctrl #(.BUILD_TIMEOUT(15)) dut_to (.clk(clk), .rst_n(rst_n), .bus(b2.slave));
  always #5 clk = ~clk;
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask
  task automatic set_slot(input int i, input logic [3:0] s, input logic [9:0] len, input logic [9:0] code);
    b.tm_sym[i*4 +: 4] = s;
    b.tm_len[i*10 +: 10] = len;
    b.tm_code[i*10 +: 10] = code;
  endtask
  task automatic build_table;
    int n;
    b.start = 1'b1;
    tick;
    b.start = 1'b0;
    b.sym_valid = 1'b0;
    chk("load_pulse", {27'd0, b.tm_sload, b.tm_en, b.busy, b.table_ready, b.bit_valid}, 32'b10100);
    chk("load_no_accept", {31'd0, b.sym_ready}, 32'd0);
    tick;
    chk("settle", {29'd0, b.tm_sload, b.tm_en, b.busy}, 32'b001);
    tick;
    n = 0;
    while (b.tm_en && n < 19) begin
      n++;
      tick;
    end
    chk("en_cycles", n, 19);
    chk("en_20th", {31'd0, b.tm_en}, 32'd1);
    b.tm_done = 1'b1;
    tick;
    b.tm_done = 1'b0;
    chk("capture", {29'd0, b.tm_en, b.busy, b.table_ready}, 32'b010);
    tick;
    chk("ready", {28'd0, b.tm_en, b.busy, b.table_ready, b.sym_ready}, 32'b0011);
  endtask
  task automatic send(input logic [3:0] s, input int len, input logic [15:0] bits, input int st_at);
    int n;
    logic [15:0] got;
    b.sym_in = s;
    b.sym_valid = 1'b1;
    chk("sym_ready_before", {31'd0, b.sym_ready}, 32'd1);
    tick;
    b.sym_valid = 1'b0;
    if (len == 0) begin
      chk("err_pulse", {31'd0, b.err_unknown}, 32'd1);
      chk("err_no_bits", {31'd0, b.bit_valid}, 32'd0);
      chk("err_sym_ready", {31'd0, b.sym_ready}, 32'd1);
      tick;
      chk("err_clear", {31'd0, b.err_unknown}, 32'd0);
    end else begin
      n = 0;
      got = '0;
      while (b.bit_valid && n < 20) begin
        got = {got[14:0], b.bit_out};
        n++;
        b.start = n == st_at;
        tick;
      end
      b.start = 1'b0;
      chk("bit_count", n, len);
      chk("bits", {16'd0, got}, {16'd0, bits});
      chk("gap_ready", {31'd0, b.sym_ready}, 32'd1);
      chk("no_reload", {30'd0, b.tm_sload, b.err_unknown}, 32'd0);
    end
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end
  initial begin
    int n;
    rst_n = 1'b0;
    b.start = 1'b0;
    b.tm_done = 1'b0;
    b.sym_valid = 1'b0;
    b.sym_in = '0;
    b.tm_sym = '0;
    b.tm_len = '0;
    b.tm_code = '0;
    b2.start = 1'b0;
    b2.tm_done = 1'b0;
    b2.sym_valid = 1'b0;
    b2.sym_in = '0;
    b2.tm_sym = '0;
    b2.tm_len = '0;
    b2.tm_code = '0;
    set_slot(0, 4'd0, 10'd2, 10'b01);
    set_slot(1, 4'd1, 10'd3, 10'b110);
    set_slot(2, 4'd5, 10'd10, 10'b1000000001);
    set_slot(3, 4'd3, 10'd0, 10'b11);
    set_slot(4, 4'd3, 10'd2, 10'b10);
    set_slot(5, 4'd7, 10'd11, 10'b1);
    set_slot(6, 4'd6, 10'd1, 10'b1);
    set_slot(7, 4'd6, 10'd2, 10'b11);
    set_slot(8, 4'd8, 10'd4, 10'b0101);
    set_slot(9, 4'd2, 10'd1, 10'b0);
    vt[0] = '{4'd0, 2, 16'b01};
    vt[1] = '{4'd1, 3, 16'b110};
    vt[2] = '{4'd9, 0, 16'd0};
    vt[3] = '{4'd3, 2, 16'b10};
    vt[4] = '{4'd6, 1, 16'b1};
    vt[5] = '{4'd8, 4, 16'b0101};
    vt[6] = '{4'd7, 0, 16'd0};
    vt[7] = '{4'd2, 1, 16'b0};
    vt[8] = '{4'd5, 10, 16'b1000000001};
    repeat (3) tick;
    chk("reset_outs", {23'd0, b.tm_sload, b.tm_en, b.sym_ready, b.bit_out, b.bit_valid, b.table_ready, b.busy, b.err_unknown, b.err_timeout}, 32'd0);
    chk("reset_outs_to", {29'd0, b2.err_timeout, b2.busy, b2.tm_en}, 32'd0);
    rst_n = 1'b1;
    b.tm_done = 1'b1;
    tick;
    b.tm_done = 1'b0;
    chk("idle_ignores_done", {27'd0, b.tm_sload, b.tm_en, b.busy, b.sym_ready, b.table_ready}, 32'd0);
    build_table;
    for (int i = 0; i < 9; i++) send(vt[i].sym, vt[i].len, vt[i].bits, -1);
    b.tm_done = 1'b1;
    tick;
    b.tm_done = 1'b0;
    chk("ready_ignores_done", {29'd0, b.busy, b.sym_ready, b.table_ready}, 32'b011);
    send(4'd5, 10, 16'b1000000001, 3);
    b.sym_in = 4'd0;
    b.sym_valid = 1'b1;
    build_table;
    send(4'd0, 2, 16'b01, -1);
    b.sym_in = 4'd1;
    b.sym_valid = 1'b1;
    tick;
    b.sym_valid = 1'b0;
    chk("rst_bit1", {30'd0, b.bit_valid, b.bit_out}, 32'b11);
    tick;
    chk("rst_bit2", {30'd0, b.bit_valid, b.bit_out}, 32'b11);
    #2 rst_n = 1'b0;
    #1;
    chk("async_drop", {28'd0, b.bit_valid, b.table_ready, b.sym_ready, b.bit_out}, 32'd0);
    tick;
    tick;
    rst_n = 1'b1;
    n = 0;
    for (int i = 0; i < 6; i++) begin
      tick;
      n += int'(b.bit_valid);
    end
    chk("no_resume", n, 0);
    chk("no_table_after_rst", {31'd0, b.table_ready}, 32'd0);
    b2.start = 1'b1;
    tick;
    b2.start = 1'b0;
    tick;
    tick;
    n = 0;
    while (b2.tm_en && n < 40) begin
      n++;
      tick;
    end
    chk("to_en_cycles", n, 15);
    chk("to_flag", {29'd0, b2.err_timeout, b2.tm_en, b2.busy}, 32'b100);
    repeat (3) tick;
    chk("to_sticky", {31'd0, b2.err_timeout}, 32'd1);
    b2.start = 1'b1;
    tick;
    b2.start = 1'b0;
    chk("to_clear_on_start", {30'd0, b2.err_timeout, b2.tm_sload}, 32'b01);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
